// File: rtl/write_stream_checker.sv
// write_stream_checker
// Watches a memory-mapped write bus for a start word on the test port. After the
// start word it compares each following test-port write against a preloaded
// table of expected values, and then reports the error count, how long the run
// took and whether it ended by timeout.
module write_stream_checker #(
    parameter int                ADDR_W     = 30,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                CHECK_NUM  = 33,
    parameter logic [ADDR_W-1:0] TEST_PORT  = 'h40,
    parameter logic [DATA_W-1:0] BEGIN_SYM  = 'h932,
    parameter int                ERR_W      = 8,
    parameter int                DUR_W      = 16,
    parameter logic [DUR_W-1:0]  MAX_CYCLES = {DUR_W{1'b1}},
    localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clear,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              first_err_vld
);

    // The compare index has to hold CHECK_NUM itself, which can be one past the last table entry.
    localparam int               CNT_W     = $clog2(CHECK_NUM + 1);
    localparam logic [CNT_W-1:0] CHECK_CNT = CNT_W'(CHECK_NUM);
    localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W + 1)'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_ONES  = '1;
    localparam logic [DUR_W-1:0] DUR_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT
    } state_t;

    state_t            state_q;
    logic [ERR_W-1:0]  errorNum_q;
    logic [DUR_W-1:0]  duration_q;
    logic              finish_q;
    logic              pass_q;
    logic              timeout_q;
    logic [IDX_W-1:0]  firstErrIdx_q;
    logic              firstErrVld_q;
    logic [CNT_W-1:0]  idx_q;
    logic              prevWen_q;

    logic [DATA_W-1:0] table_q [DEPTH];

    logic [IDX_W-1:0]  tblIdx;
    logic              testPortWr;
    logic              acceptWr;
    logic              beginSeen;
    logic              mismatch;
    logic              idxDone;
    logic              timeHit;
    logic [DUR_W-1:0]  duration_d;
    logic [ERR_W-1:0]  errorNum_d;
    logic [CNT_W-1:0]  idx_d;

    // A held wen counts once: only its rising edge makes an accepted write.
    assign testPortWr = wen && (addr == TEST_PORT);
    assign acceptWr   = testPortWr && !prevWen_q;
    assign beginSeen  = testPortWr && (data == BEGIN_SYM);
    assign tblIdx     = IDX_W'(idx_q);
    assign mismatch   = (data != table_q[tblIdx]);
    assign idxDone    = (idx_q == CHECK_CNT);
    assign timeHit    = (duration_q == MAX_CYCLES);

    // Saturating increments for the run counters, plus the next compare index.
    always_comb begin
        duration_d = duration_q;
        errorNum_d = errorNum_q;
        idx_d      = idx_q + 1'b1;
        if (duration_q != DUR_ONES) begin
            duration_d = duration_q + 1'b1;
        end
        if (errorNum_q != ERR_ONES) begin
            errorNum_d = errorNum_q + 1'b1;
        end
    end

    // Expected-value table; only loadable while idle, and deliberately not reset so it survives an aborted run.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == IDLE) && ({1'b0, ld_idx} < DEPTH_EXT)) begin
            table_q[ld_idx] <= ld_data;
        end
    end

    // Checker state machine with all status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            errorNum_q    <= ERR_ONES;
            duration_q    <= '0;
            finish_q      <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            firstErrIdx_q <= '0;
            firstErrVld_q <= 1'b0;
            idx_q         <= '0;
            prevWen_q     <= 1'b1;
        end else begin
            prevWen_q <= wen;
            case (state_q)
                IDLE: begin
                    if (beginSeen) begin
                        state_q       <= CHECK;
                        errorNum_q    <= '0;
                        duration_q    <= '0;
                        idx_q         <= '0;
                        firstErrIdx_q <= '0;
                        firstErrVld_q <= 1'b0;
                        timeout_q     <= 1'b0;
                        finish_q      <= 1'b0;
                        pass_q        <= 1'b0;
                    end
                end
                CHECK: begin
                    if (idxDone) begin
                        // Completion is tested first so it beats a timeout landing on the same cycle.
                        state_q   <= REPORT;
                        finish_q  <= 1'b1;
                        pass_q    <= (errorNum_q == '0);
                        timeout_q <= 1'b0;
                    end else if (timeHit) begin
                        state_q   <= REPORT;
                        finish_q  <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        duration_q <= duration_d;
                        if (acceptWr) begin
                            idx_q <= idx_d;
                            if (mismatch) begin
                                errorNum_q <= errorNum_d;
                                if (!firstErrVld_q) begin
                                    firstErrVld_q <= 1'b1;
                                    firstErrIdx_q <= tblIdx;
                                end
                            end
                        end
                    end
                end
                REPORT: begin
                    if (clear) begin
                        state_q    <= IDLE;
                        errorNum_q <= ERR_ONES;
                        duration_q <= '0;
                        finish_q   <= 1'b0;
                        pass_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign error_num     = errorNum_q;
    assign duration      = duration_q;
    assign finish        = finish_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign first_err_idx = firstErrIdx_q;
    assign first_err_vld = firstErrVld_q;

endmodule
